sram_dp_ctrl: RTL

//  Initiator-side controller that drives the 16x8 dual-port synchronous SRAM.
//  - Accepts write and read requests over valid/ready channels.
//  - Sequences the SRAM wr/rd ports and issues its reset pulse.
//  - Returns read data in order on a back-pressurable response channel.
//  - Owns same-address read/write collision handling, so clients never see SRAM hazards.

---
 rtl/sram_dp_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sram_dp_ctrl.sv
// Initiator-side controller for a 16x8 dual-port synchronous SRAM: valid/ready request channels,
// in-order back-pressurable read responses. Define SRAM_DP_CTRL_FWD_EN to forward colliding writes instead of stalling reads.
module sram_dp_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_rst,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OUT_W = $clog2(RSP_DEPTH + RD_LAT + 2);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t state, state_next;
    logic   run;

    logic              wr_fire, rd_fire, collide, credit_ok;
    logic [RD_LAT:0]   rd_pipe;
    logic [OUT_W-1:0]  inflight, outstanding;

    logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              push, pop;
    logic [DATA_W-1:0] push_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        mem_rst = (state == ST_INIT);
        run     = (state == ST_RUN);
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) inflight = inflight + OUT_W'(rd_pipe[i]);
    end

    assign outstanding = OUT_W'(fifo_count) + inflight;
    assign credit_ok   = (outstanding < OUT_W'(RSP_DEPTH));
    assign wr_ready    = run;
    assign wr_fire     = wr_valid & wr_ready;
    assign collide     = wr_fire & rd_valid & (wr_addr == rd_addr);
`ifdef SRAM_DP_CTRL_FWD_EN
    assign rd_ready    = run & credit_ok;
`else
    // Stalling the read lets the write land first, so next cycle's read sees new data.
    assign rd_ready    = run & credit_ok & ~collide;
`endif
    assign rd_fire     = rd_valid & rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_rd_addr <= '0;
            mem_data_in <= '0;
        end else begin
            mem_wr_en <= wr_fire;
            mem_rd_en <= rd_fire;
            if (wr_fire) begin
                mem_wr_addr <= wr_addr;
                mem_data_in <= wr_data;
            end
            if (rd_fire) mem_rd_addr <= rd_addr;
        end
    end

    // Stage k is set k edges after accept; the last stage marks the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pipe <= '0;
        else        rd_pipe <= {rd_pipe[RD_LAT-1:0], rd_fire};
    end

`ifdef SRAM_DP_CTRL_FWD_EN
    logic [RD_LAT:0]   fwd_pipe;
    logic [DATA_W-1:0] fwd_data [RD_LAT+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_pipe <= '0;
            for (int i = 0; i <= RD_LAT; i++) fwd_data[i] <= '0;
        end else begin
            fwd_pipe    <= {fwd_pipe[RD_LAT-1:0], rd_fire & collide};
            fwd_data[0] <= wr_data;
            for (int i = 1; i <= RD_LAT; i++) fwd_data[i] <= fwd_data[i-1];
        end
    end

    assign push_data = fwd_pipe[RD_LAT] ? fwd_data[RD_LAT] : mem_data_out;
`else
    assign push_data = mem_data_out;
`endif

    assign push      = rd_pipe[RD_LAT];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
